// File: rtl/fft_twiddle_mult_hs_if.sv
`default_nettype none
// ============================================================================
// Module   : fft_twiddle_mult_hs_if
// Purpose  : Sample-in / product-out handshake bundle for the twiddle
//            multiplier. "master" drives samples in and accepts products,
//            "slave" is the multiplier side.
// Revision : 1.0 - initial release
// ============================================================================
interface fft_twiddle_mult_hs_if #(
    parameter int DATA_WIDTH    = 25,
    parameter int TWIDDLE_WIDTH = 10,
    parameter int NLOG2         = 10
);
    logic                     in_valid_i;
    logic                     in_ready_o;
    logic                     conj_i;
    logic [NLOG2-1:0]         ctr_i;
    logic [DATA_WIDTH-1:0]    x_re_i;
    logic [DATA_WIDTH-1:0]    x_im_i;
    logic [TWIDDLE_WIDTH-1:0] w_re_i;
    logic [TWIDDLE_WIDTH-1:0] w_im_i;
    logic                     out_valid_o;
    logic                     out_ready_i;
    logic [NLOG2-1:0]         ctr_o;
    logic [DATA_WIDTH-1:0]    z_re_o;
    logic [DATA_WIDTH-1:0]    z_im_o;

    modport master (
        output in_valid_i, conj_i, ctr_i, x_re_i, x_im_i, w_re_i, w_im_i, out_ready_i,
        input  in_ready_o, out_valid_o, ctr_o, z_re_o, z_im_o
    );

    modport slave (
        input  in_valid_i, conj_i, ctr_i, x_re_i, x_im_i, w_re_i, w_im_i, out_ready_i,
        output in_ready_o, out_valid_o, ctr_o, z_re_o, z_im_o
    );
endinterface
`default_nettype wire

// File: rtl/fft_twiddle_mult_hs.sv
`default_nettype none
// ============================================================================
// Module   : fft_twiddle_mult_hs
// Purpose  : Complex twiddle multiplier z = x * w (or x * conj(w)) for the
//            R2^2SDF FFT. A single shared multiplier evaluates the 3-multiply
//            Karatsuba form over three cycles; valid/ready on both sides and
//            the FFT counter tag travels with the sample.
// Revision : 1.0 - initial release
// ============================================================================
module fft_twiddle_mult_hs #(
    parameter int DATA_WIDTH    = 25,
    parameter int TWIDDLE_WIDTH = 10,
    parameter int NLOG2         = 10,
    parameter int ROUND         = 0,
    parameter int SATURATE      = 0
) (
    input  logic                  clk_i,
    input  logic                  rst_n,
    fft_twiddle_mult_hs_if.slave  bus
);

    // Full-precision accumulator width; Karatsuba partial sums never overflow it.
    localparam int c_acc_w = DATA_WIDTH + TWIDDLE_WIDTH + 2;
    localparam int c_hi    = DATA_WIDTH + TWIDDLE_WIDTH - 2;
    localparam int c_lo    = TWIDDLE_WIDTH - 1;
    localparam int c_ext_w = c_acc_w - c_hi - 1;

    localparam logic [c_acc_w-1:0]    c_rnd = c_acc_w'(ROUND != 0) << (TWIDDLE_WIDTH - 2);
    localparam logic [DATA_WIDTH-1:0] c_max = {1'b0, {(DATA_WIDTH-1){1'b1}}};
    localparam logic [DATA_WIDTH-1:0] c_min = {1'b1, {(DATA_WIDTH-1){1'b0}}};

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_MF   = 3'd1,
        S_MR   = 3'd2,
        S_MI   = 3'd3,
        S_HOLD = 3'd4
    } state_t;

    state_t r_state;
    state_t w_state_nxt;

    logic signed [DATA_WIDTH-1:0]    r_a, r_b;
    logic signed [TWIDDLE_WIDTH-1:0] r_c, r_d;
    logic        [NLOG2-1:0]         r_tag;
    logic signed [c_acc_w-1:0]       r_f, r_r, r_i;
    logic        [DATA_WIDTH-1:0]    r_z_re, r_z_im;
    logic        [NLOG2-1:0]         r_ctr_o;
    logic                            r_out_valid;

    logic                            w_capture, w_cap_f, w_cap_r, w_hold, w_load;
    logic                            w_slot_free;
    logic signed [DATA_WIDTH:0]      w_ma;
    logic signed [TWIDDLE_WIDTH:0]   w_mb;
    logic signed [c_acc_w-1:0]       w_prod;
    logic signed [c_acc_w-1:0]       w_i;
    logic        [DATA_WIDTH-1:0]    w_z_re, w_z_im;

    // Round, drop the Q-fraction bits, then saturate or wrap to DATA_WIDTH.
    function automatic logic [DATA_WIDTH-1:0] form_out(input logic [c_acc_w-1:0] v);
        logic [c_acc_w-1:0]    s;
        logic [DATA_WIDTH-1:0] k;
        logic                  ovf;
        s   = v + c_rnd;
        k   = s[c_hi:c_lo];
        ovf = (s[c_acc_w-1:c_hi+1] != {c_ext_w{k[DATA_WIDTH-1]}});
        if ((SATURATE != 0) && ovf)
            form_out = s[c_acc_w-1] ? c_min : c_max;
        else
            form_out = k;
    endfunction

    assign w_slot_free = !r_out_valid || bus.out_ready_i;

    // State register.
    always_ff @(posedge clk_i or negedge rst_n) begin
        if (!rst_n) r_state <= S_IDLE;
        else        r_state <= w_state_nxt;
    end

    // Next-state and per-phase strobes.
    always_comb begin
        w_state_nxt = r_state;
        w_capture   = 1'b0;
        w_cap_f     = 1'b0;
        w_cap_r     = 1'b0;
        w_hold      = 1'b0;
        w_load      = 1'b0;
        case (r_state)
            S_IDLE: if (bus.in_valid_i) begin
                w_capture   = 1'b1;
                w_state_nxt = S_MF;
            end
            S_MF: begin
                w_cap_f     = 1'b1;
                w_state_nxt = S_MR;
            end
            S_MR: begin
                w_cap_r     = 1'b1;
                w_state_nxt = S_MI;
            end
            S_MI: begin
                if (w_slot_free) begin
                    w_load      = 1'b1;
                    w_state_nxt = S_IDLE;
                end else begin
                    w_hold      = 1'b1;
                    w_state_nxt = S_HOLD;
                end
            end
            S_HOLD: if (w_slot_free) begin
                w_load      = 1'b1;
                w_state_nxt = S_IDLE;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Shared multiplier operand select: (a-b)*c, then b*(c-d), then a*(c+d).
    always_comb begin
        w_ma = '0;
        w_mb = '0;
        case (r_state)
            S_MF: begin
                w_ma = {r_a[DATA_WIDTH-1], r_a} - {r_b[DATA_WIDTH-1], r_b};
                w_mb = {r_c[TWIDDLE_WIDTH-1], r_c};
            end
            S_MR: begin
                w_ma = {r_b[DATA_WIDTH-1], r_b};
                w_mb = {r_c[TWIDDLE_WIDTH-1], r_c} - {r_d[TWIDDLE_WIDTH-1], r_d};
            end
            S_MI: begin
                w_ma = {r_a[DATA_WIDTH-1], r_a};
                w_mb = {r_c[TWIDDLE_WIDTH-1], r_c} + {r_d[TWIDDLE_WIDTH-1], r_d};
            end
            default: begin
                w_ma = '0;
                w_mb = '0;
            end
        endcase
    end

    assign w_prod = c_acc_w'(w_ma) * c_acc_w'(w_mb);
    assign w_i    = (r_state == S_HOLD) ? r_i : (w_prod - r_f);
    assign w_z_re = form_out(r_r);
    assign w_z_im = form_out(w_i);

    // Capture the accepted sample; the conjugate is folded into the stored w_im.
    always_ff @(posedge clk_i or negedge rst_n) begin
        if (!rst_n) begin
            r_a   <= '0;
            r_b   <= '0;
            r_c   <= '0;
            r_d   <= '0;
            r_tag <= '0;
        end else if (w_capture) begin
            r_a   <= bus.x_re_i;
            r_b   <= bus.x_im_i;
            r_c   <= bus.w_re_i;
            r_d   <= bus.conj_i ? -bus.w_im_i : bus.w_im_i;
            r_tag <= bus.ctr_i;
        end
    end

    // Karatsuba partial results: f, R, and I when the output slot is busy.
    always_ff @(posedge clk_i or negedge rst_n) begin
        if (!rst_n) begin
            r_f <= '0;
            r_r <= '0;
            r_i <= '0;
        end else begin
            if (w_cap_f) r_f <= w_prod;
            if (w_cap_r) r_r <= w_prod + r_f;
            if (w_hold)  r_i <= w_i;
        end
    end

    // Output register; a load in the same cycle as a transfer keeps valid high.
    always_ff @(posedge clk_i or negedge rst_n) begin
        if (!rst_n) begin
            r_out_valid <= 1'b0;
            r_z_re      <= '0;
            r_z_im      <= '0;
            r_ctr_o     <= '0;
        end else if (w_load) begin
            r_out_valid <= 1'b1;
            r_z_re      <= w_z_re;
            r_z_im      <= w_z_im;
            r_ctr_o     <= r_tag;
        end else if (bus.out_ready_i) begin
            r_out_valid <= 1'b0;
        end
    end

    assign bus.in_ready_o  = (r_state == S_IDLE);
    assign bus.out_valid_o = r_out_valid;
    assign bus.z_re_o      = r_z_re;
    assign bus.z_im_o      = r_z_im;
    assign bus.ctr_o       = r_ctr_o;

endmodule
`default_nettype wire
